// File: rtl/seq_feed_ctrl.sv
// seq_feed_ctrl: latches a switch word on a synchronised button press, feeds it
// MSB-first to a serial detector at one bit per TICK_DIV clocks, counts the
// detector's hit pulses (saturating) and reports "any hit" on led.
module seq_feed_ctrl #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active low
  input  logic             button,
  input  logic [WIDTH-1:0] switch,
  input  logic             det_hit,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             led
);

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] HIT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       sync_q, sync_d;      // [0]=s1, [1]=s2, [2]=s3
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0] bitcnt_q, bitcnt_d;
  logic [DIV_W-1:0] divcnt_q, divcnt_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic             led_q, led_d;

  logic rise;
  logic tick;

  assign rise = sync_q[1] & ~sync_q[2];
  assign tick = (divcnt_q == DIV_LAST);

  // Next-state and next-output computation for the whole controller.
  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[1:0], button};
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    divcnt_d    = divcnt_q;
    bit_out_d   = bit_out_q;          // holds last sent bit between strobes
    bit_valid_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    hit_cnt_d   = hit_cnt_q;
    led_d       = led_q;

    // Hits are accepted through DONE so a detector with one cycle of latency
    // still gets its verdict on the last bit counted.
    if ((state_q != S_IDLE) && det_hit && (hit_cnt_q != HIT_MAX)) begin
      hit_cnt_d = hit_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d   = S_SHIFT;
          shreg_d   = switch;
          bitcnt_d  = '0;
          divcnt_d  = '0;
          hit_cnt_d = '0;
          led_d     = 1'b0;
          busy_d    = 1'b1;
        end
      end
      S_SHIFT: begin
        if (tick) begin
          divcnt_d    = '0;
          bit_out_d   = shreg_q[WIDTH-1];
          bit_valid_d = 1'b1;
          shreg_d     = shreg_q << 1;
          bitcnt_d    = bitcnt_q + 1'b1;
          if (bitcnt_q == BIT_LAST) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          divcnt_d = divcnt_q + 1'b1;
        end
      end
      S_DONE: begin
        led_d   = (hit_cnt_q != '0) | det_hit;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any word in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sync_q      <= '0;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      divcnt_q    <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hit_cnt_q   <= '0;
      led_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      divcnt_q    <= divcnt_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      hit_cnt_q   <= hit_cnt_d;
      led_q       <= led_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign hit_cnt   = hit_cnt_q;
  assign led       = led_q;

endmodule

// File: tb/tb_seq_feed_ctrl.sv
// Bench for seq_feed_ctrl: table of whole-word runs plus hand-written reset,
// mid-word reset and saturation sequences. All sampling happens on negedges.
module tb_seq_feed_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic [7:0] switch;
  logic       det_hit;
  logic       bit_out;
  logic       bit_valid;
  logic       busy;
  logic       done;
  logic [3:0] hit_cnt;
  logic       led;

  int n_checks = 0;
  int n_fail   = 0;

  seq_feed_ctrl #(.WIDTH(8), .TICK_DIV(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .button    (button),
    .switch    (switch),
    .det_hit   (det_hit),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .busy      (busy),
    .done      (done),
    .hit_cnt   (hit_cnt),
    .led       (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sw;
    logic [7:0] hit_mask;   // bit j: pulse det_hit right after strobe j+1
    bit         press2;     // extra press while shifting
    bit         chg;        // change switch mid-word
    logic [7:0] exp_bits;
    int         exp_hits;
    int         exp_led;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Presses the button for 20 ns and watches one whole word.
  task automatic do_word(input int idx, input vec_t v);
    int first_busy = -1;
    int first_strobe = -1;
    int last_strobe = 0;
    int busy_cyc = 0;
    int strobes = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int spacing_err = 0;
    int led_start = -1;
    logic [7:0] bits = 8'h00;
    @(negedge clk);
    switch = v.sw;
    button = 1'b1;
    for (int i = 0; i < 46; i++) begin
      @(negedge clk);
      if (busy) begin
        if (first_busy < 0) begin
          first_busy = i;
          led_start  = int'(led);
        end
        busy_cyc++;
      end
      if (bit_valid) begin
        bits = {bits[6:0], bit_out};
        strobes++;
        if (strobes == 1) first_strobe = i;
        else if (i - last_strobe != 4) spacing_err++;
        last_strobe = i;
      end
      if (done) begin
        done_cnt++;
        done_cyc = i;
      end
      det_hit = bit_valid && (strobes >= 1) && (strobes <= 8) && v.hit_mask[strobes-1];
      button  = (i == 0) || (v.press2 && i >= 12 && i < 15);
      if (v.chg && i == 10) switch = ~v.sw;
    end
    det_hit = 1'b0;
    check("start_latency", first_busy, 2);
    check("led_clear_at_start", led_start, 0);
    check("first_strobe", first_strobe, 6);
    check("strobe_count", strobes, 8);
    check("strobe_spacing_err", spacing_err, 0);
    check("bit_sequence", int'(bits), int'(v.exp_bits));
    check("busy_cycles", busy_cyc, 32);
    check("done_count", done_cnt, 1);
    check("done_cycle", done_cyc, 34);
    check("hit_cnt", int'(hit_cnt), v.exp_hits);
    check("led", int'(led), v.exp_led);
    repeat (4) @(negedge clk);
    check("led_hold", int'(led), v.exp_led);
    $display("word %0d sw=%h bits=%h hits=%0d led=%0d", idx, v.sw, bits, hit_cnt, led);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    vecs[0] = '{sw: 8'hFA, hit_mask: 8'h00, press2: 1'b0, chg: 1'b0, exp_bits: 8'hFA, exp_hits: 0, exp_led: 0};
    vecs[1] = '{sw: 8'h55, hit_mask: 8'h88, press2: 1'b0, chg: 1'b0, exp_bits: 8'h55, exp_hits: 2, exp_led: 1};
    vecs[2] = '{sw: 8'h3C, hit_mask: 8'h00, press2: 1'b1, chg: 1'b1, exp_bits: 8'h3C, exp_hits: 0, exp_led: 0};
    vecs[3] = '{sw: 8'h81, hit_mask: 8'hFF, press2: 1'b0, chg: 1'b0, exp_bits: 8'h81, exp_hits: 8, exp_led: 1};

    // Reset held with button pressed: everything stays zero.
    rst = 1'b0;
    button = 1'b1;
    switch = 8'hFA;
    det_hit = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("reset_outputs", int'({bit_out, bit_valid, busy, done, hit_cnt, led}), 0);
    end
    button = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_after_reset", int'(busy), 0);
    $display("reset sequence done outputs=%0d", {bit_out, bit_valid, busy, done, hit_cnt, led});

    for (int k = 0; k < 4; k++) do_word(k, vecs[k]);

    // Reset after the third strobe aborts the word.
    @(negedge clk);
    switch = 8'hC3;
    button = 1'b1;
    @(negedge clk);
    button = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && seen < 3; i++) begin
      @(negedge clk);
      if (bit_valid) seen++;
    end
    check("strobes_before_reset", seen, 3);
    rst = 1'b0;
    #1;
    check("midword_reset_outputs", int'({bit_out, bit_valid, busy, done, hit_cnt, led}), 0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy || done || bit_valid) seen++;
    end
    check("no_resume_after_reset", seen, 0);
    $display("midword reset done");
    do_word(4, '{sw: 8'h5A, hit_mask: 8'h00, press2: 1'b0, chg: 1'b0, exp_bits: 8'h5A, exp_hits: 0, exp_led: 0});

    // det_hit held 20 cycles inside SHIFT: counter saturates at 15.
    @(negedge clk);
    switch = 8'h00;
    button = 1'b1;
    @(negedge clk);
    button = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
    check("sat_busy", int'(busy), 1);
    det_hit = 1'b1;
    repeat (10) @(negedge clk);
    check("sat_cnt_10", int'(hit_cnt), 10);
    repeat (10) @(negedge clk);
    check("sat_cnt_15", int'(hit_cnt), 15);
    det_hit = 1'b0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("sat_done", seen, 1);
    @(negedge clk);
    check("sat_led", int'(led), 1);
    check("sat_final_cnt", int'(hit_cnt), 15);
    $display("saturation word hits=%0d led=%0d", hit_cnt, led);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
